// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the time-shared multiplier arbiter.
package mul_share_pkg;

    // Widest requester id ever needed (up to 8 requesters).
    localparam int ID_MAX_W = 3;

    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Control half of a pipeline stage; operands and partial products
    // travel in the multiplier's own registers so they map onto the DSP.
    typedef struct packed {
        logic                vld;
        logic [ID_MAX_W-1:0] id;
    } stage_ctl_t;

endpackage

// File: rtl/mul_share_pipe.sv
// LATENCY-stage unsigned WIDTH x WIDTH multiplier, product truncated to WIDTH,
// with a global hold enable. Operand/product registers follow the DSP A/B, M, P layout.
module mul_share_pipe
    import mul_share_pkg::*;
#(
    parameter int WIDTH   = 18,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  stage_ctl_t       ctl_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output stage_ctl_t       ctl_out,
    output logic [WIDTH-1:0] p_out
);

    stage_ctl_t ctl_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) ctl_q[i] <= '0;
        end else if (en) begin
            ctl_q[0] <= ctl_in;
            for (int i = 1; i < LATENCY; i++) ctl_q[i] <= ctl_q[i-1];
        end
    end

    assign ctl_out = ctl_q[LATENCY-1];

    if (LATENCY == 1) begin : g_lat1
        logic [WIDTH-1:0] p_p0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  p_p0 <= '0;
            else if (en) p_p0 <= a_in * b_in;
        end

        assign p_out = p_p0;
    end else begin : g_latn
        logic [WIDTH-1:0] a_p0, b_p0;
        logic [WIDTH-1:0] p_out_q;

        // stage 0: operand registers
        always_ff @(posedge clk) begin
            if (en) begin
                a_p0 <= a_in;
                b_p0 <= b_in;
            end
        end

        if (LATENCY == 2) begin : g_m_direct
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  p_out_q <= '0;
                else if (en) p_out_q <= a_p0 * b_p0;
            end
        end else begin : g_m_chain
            logic [WIDTH-1:0] p_mid [LATENCY-2];

            // stages 1..LATENCY-2: multiplier and intermediate product registers
            always_ff @(posedge clk) begin
                if (en) begin
                    p_mid[0] <= a_p0 * b_p0;
                    for (int i = 1; i < LATENCY-2; i++) p_mid[i] <= p_mid[i-1];
                end
            end

            // final stage: output register, cleared so rsp_p reads 0 after reset
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  p_out_q <= '0;
                else if (en) p_out_q <= p_mid[LATENCY-3];
            end
        end

        assign p_out = p_out_q;
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter feeding one shared multiplier pipeline with backpressure.
// Optional per-requester transfer counters: define MUL_SHARE_ARBITER_STATS_EN.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 18,
    parameter int LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_p,
    output logic [id_w(NUM_REQ)-1:0]   rsp_id
`ifdef MUL_SHARE_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]      stat_issued
`endif
);

    localparam int IDW = id_w(NUM_REQ);

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     scan_idx;
    logic [IDW-1:0]     gnt_idx;
    logic               gnt_any;
    logic [NUM_REQ-1:0] gnt;
    logic               stall;
    stage_ctl_t         ctl_in, ctl_out;
    logic [WIDTH-1:0]   a_sel, b_sel;
    logic [ID_MAX_W-1:0] id_unused;

    assign stall = ctl_out.vld & ~rsp_ready;

    // First valid requester at or after ptr, wrapping; nothing while stalled or in reset.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        scan_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            scan_idx = IDW'((int'(ptr) + off) % NUM_REQ);
            if (!gnt_any && req_valid[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        if (stall || !rst_n) gnt_any = 1'b0;
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    assign req_ready = gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ptr <= '0;
        else if (gnt_any) ptr <= IDW'((int'(gnt_idx) + 1) % NUM_REQ);
    end

    assign a_sel      = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    assign b_sel      = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
    assign ctl_in.vld = gnt_any;
    assign ctl_in.id  = ID_MAX_W'(gnt_idx);

    mul_share_pipe #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (~stall),
        .ctl_in  (ctl_in),
        .a_in    (a_sel),
        .b_in    (b_sel),
        .ctl_out (ctl_out),
        .p_out   (rsp_p)
    );

    assign rsp_valid = ctl_out.vld;
    assign rsp_id    = ctl_out.id[IDW-1:0];
    assign id_unused = ctl_out.id;

`ifdef MUL_SHARE_ARBITER_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        logic [31:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                     cnt <= '0;
            else if (gnt[i] && cnt != '1)   cnt <= cnt + 32'd1;
        end

        assign stat_issued[i*32 +: 32] = cnt;
    end
`endif

endmodule
